// File: rtl/aha_sram4kx64_arb_pkg.sv
// Shared types and constants for the SRAM arbiter/initialiser slice.
package aha_sram_ctrl_pkg;

  // Controller state: zero-fill after reset, then normal arbitration.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Requester identifiers, also the encoding of rr_last and the read tag.
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // Widest byte-enable vector the read-detect helper accepts (DATA_W up to 128).
  localparam int WEN_MAX = 16;

  // READ_WEn helper: a request is a read when every active-low byte enable is 1.
  // Callers pad unused upper lanes with ones.
  function automatic logic is_read_wen(input logic [WEN_MAX-1:0] wen_padded);
    return &wen_padded;
  endfunction

endpackage

// File: rtl/aha_sram4kx64_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the SRAM pins.
interface aha_sram4kx64_arb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  localparam int LANES = DATA_W / 8;

  logic              P0_REQ;
  logic [LANES-1:0]  P0_WEn;
  logic [ADDR_W-1:0] P0_A;
  logic [DATA_W-1:0] P0_D;
  logic              P0_READY;
  logic              P0_RVALID;
  logic [DATA_W-1:0] P0_RDATA;

  logic              P1_REQ;
  logic [LANES-1:0]  P1_WEn;
  logic [ADDR_W-1:0] P1_A;
  logic [DATA_W-1:0] P1_D;
  logic              P1_READY;
  logic              P1_RVALID;
  logic [DATA_W-1:0] P1_RDATA;

  logic              SRAM_CEn;
  logic [LANES-1:0]  SRAM_WEn;
  logic [ADDR_W-1:0] SRAM_A;
  logic [DATA_W-1:0] SRAM_D;
  logic [DATA_W-1:0] SRAM_Q;

  logic              INIT_DONE;

  // Arbiter side.
  modport slave (
    input  P0_REQ, P0_WEn, P0_A, P0_D,
    input  P1_REQ, P1_WEn, P1_A, P1_D,
    input  SRAM_Q,
    output P0_READY, P0_RVALID, P0_RDATA,
    output P1_READY, P1_RVALID, P1_RDATA,
    output SRAM_CEn, SRAM_WEn, SRAM_A, SRAM_D,
    output INIT_DONE
  );

  // Requester / SRAM-macro side.
  modport master (
    output P0_REQ, P0_WEn, P0_A, P0_D,
    output P1_REQ, P1_WEn, P1_A, P1_D,
    output SRAM_Q,
    input  P0_READY, P0_RVALID, P0_RDATA,
    input  P1_READY, P1_RVALID, P1_RDATA,
    input  SRAM_CEn, SRAM_WEn, SRAM_A, SRAM_D,
    input  INIT_DONE
  );
endinterface

// File: rtl/aha_sram4kx64_arb_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-winner.
module aha_rr_arb2
  import aha_sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_vld,
  output logic       gnt_port
);

  logic rr_last_r;

  // Pick the single requester, or on a tie the port that did not win last.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = P0;
    if (en && (req != 2'b00)) begin
      gnt_vld = 1'b1;
      if (req == 2'b11) begin
        gnt_port = ~rr_last_r;
      end else if (req[1]) begin
        gnt_port = P1;
      end else begin
        gnt_port = P0;
      end
    end else begin
      gnt_vld = 1'b0;
    end
  end

  // Remember the last winner; reset to P1 so P0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_r <= P1;
    end else if (gnt_vld) begin
      rr_last_r <= gnt_port;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

endmodule

// File: rtl/aha_sram4kx64_arb.sv
// Two-port round-robin arbiter and power-up zero-fill for a 4Kx64 byte-lane SRAM.
module aha_sram4kx64_arb
  import aha_sram_ctrl_pkg::*;
#(
  parameter int              ADDR_W        = 12,
  parameter int              DATA_W        = 64,
  parameter bit              INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE  = {DATA_W{1'b0}}
)(
  input  logic              CLK,
  input  logic              RESET,
  aha_sram4kx64_arb_if.slave bus
);

  localparam int                LANES       = DATA_W / 8;
  localparam logic [ADDR_W-1:0] INIT_LAST   = {ADDR_W{1'b1}};
  localparam state_t            RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

  state_t            state_r;
  logic [ADDR_W-1:0] init_cnt_r;
  logic              done_r;
  logic              tag_vld_r;
  logic              tag_port_r;

  logic              arb_en_s;
  logic              gnt_vld_s;
  logic              gnt_port_s;
  logic [LANES-1:0]  sel_wen_s;
  logic [ADDR_W-1:0] sel_a_s;
  logic [DATA_W-1:0] sel_d_s;
  logic              sel_read_s;

  assign arb_en_s = (state_r == ST_RUN) && !RESET;

  aha_rr_arb2 u_arb (
    .clk      (CLK),
    .rst      (RESET),
    .en       (arb_en_s),
    .req      ({bus.P1_REQ, bus.P0_REQ}),
    .gnt_vld  (gnt_vld_s),
    .gnt_port (gnt_port_s)
  );

  // Route the granted port's command fields toward the SRAM pins.
  always_comb begin
    if (gnt_port_s == P1) begin
      sel_wen_s = bus.P1_WEn;
      sel_a_s   = bus.P1_A;
      sel_d_s   = bus.P1_D;
    end else begin
      sel_wen_s = bus.P0_WEn;
      sel_a_s   = bus.P0_A;
      sel_d_s   = bus.P0_D;
    end
  end

  assign sel_read_s = is_read_wen(WEN_MAX'({{WEN_MAX{1'b1}}, sel_wen_s}));

  // SRAM pin mux and READY: idle under reset, fill writes in INIT, granted access in RUN.
  always_comb begin
    bus.SRAM_CEn = 1'b1;
    bus.SRAM_WEn = {LANES{1'b1}};
    bus.SRAM_A   = {ADDR_W{1'b0}};
    bus.SRAM_D   = {DATA_W{1'b0}};
    bus.P0_READY = 1'b0;
    bus.P1_READY = 1'b0;
    if (RESET) begin
      bus.SRAM_CEn = 1'b1;
    end else if (state_r == ST_INIT) begin
      bus.SRAM_CEn = 1'b0;
      bus.SRAM_WEn = {LANES{1'b0}};
      bus.SRAM_A   = init_cnt_r;
      bus.SRAM_D   = INIT_VALUE;
    end else if (gnt_vld_s) begin
      bus.SRAM_CEn = 1'b0;
      bus.SRAM_WEn = sel_wen_s;
      bus.SRAM_A   = sel_a_s;
      bus.SRAM_D   = sel_d_s;
      bus.P0_READY = (gnt_port_s == P0);
      bus.P1_READY = (gnt_port_s == P1);
    end else begin
      bus.SRAM_CEn = 1'b1;
    end
  end

  // Controller FSM: fill counter, done flag and the 1-deep read tag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= RESET_STATE;
      init_cnt_r <= {ADDR_W{1'b0}};
      done_r     <= !INIT_ON_RESET;
      tag_vld_r  <= 1'b0;
      tag_port_r <= P0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          tag_vld_r  <= 1'b0;
          if (init_cnt_r == INIT_LAST) begin
            state_r <= ST_RUN;
            done_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          tag_vld_r  <= gnt_vld_s && sel_read_s;
          tag_port_r <= gnt_port_s;
        end
        default: begin
          state_r    <= RESET_STATE;
          init_cnt_r <= {ADDR_W{1'b0}};
          done_r     <= !INIT_ON_RESET;
          tag_vld_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read data returns straight from the macro; a reset squashes the pending response.
  assign bus.P0_RVALID = tag_vld_r && (tag_port_r == P0) && !RESET;
  assign bus.P1_RVALID = tag_vld_r && (tag_port_r == P1) && !RESET;
  assign bus.P0_RDATA  = bus.SRAM_Q;
  assign bus.P1_RDATA  = bus.SRAM_Q;
  assign bus.INIT_DONE = done_r && !(RESET && INIT_ON_RESET);

endmodule

// File: tb/tb_aha_sram4kx64_arb.sv
// Directed bench for aha_sram4kx64_arb: zero-fill, arbitration, read tag, reset.
module tb_aha_sram4kx64_arb;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 64;
  localparam int LANES  = 8;
  localparam int DEPTH  = 4096;

  localparam logic [63:0] DB = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] BW = 64'h1111_2222_3333_44AA;
  localparam logic [63:0] AA = 64'h0000_0000_0000_00AA;

  logic clk;
  logic rst;
  logic prefill;
  int   total;
  int   bad;

  logic [63:0] mem [0:DEPTH-1];

  aha_sram4kx64_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  aha_sram4kx64_arb #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .INIT_ON_RESET (1'b1),
    .INIT_VALUE    (64'h0)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: byte-lane writes at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (prefill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'hBADC0DE0_00000000 | 64'(i);
    end else if (!bus.SRAM_CEn) begin
      for (int b = 0; b < LANES; b++)
        if (!bus.SRAM_WEn[b]) mem[bus.SRAM_A][b*8 +: 8] <= bus.SRAM_D[b*8 +: 8];
      if (&bus.SRAM_WEn) bus.SRAM_Q <= mem[bus.SRAM_A];
    end
  end

  typedef struct {
    logic        req0, req1;
    logic [7:0]  wen0, wen1;
    logic [11:0] a0, a1;
    logic [63:0] d0, d1;
    logic        rdy0, rdy1, rv0, rv1;
    logic        cen;
    logic [11:0] exp_a;
    logic [63:0] rdata;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.P0_REQ = 1'b0; bus.P0_WEn = 8'hFF; bus.P0_A = 12'h000; bus.P0_D = 64'h0;
    bus.P1_REQ = 1'b0; bus.P1_WEn = 8'hFF; bus.P1_A = 12'h000; bus.P1_D = 64'h0;
  endtask

  // Walk the whole fill sequence checking every cycle, then report it as one comparison.
  task automatic wait_init();
    int errs;
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (bus.SRAM_CEn !== 1'b0 || bus.SRAM_WEn !== 8'h00 || bus.SRAM_A !== ADDR_W'(i) ||
          bus.SRAM_D !== 64'h0 || bus.P0_READY !== 1'b0 || bus.P1_READY !== 1'b0 ||
          bus.INIT_DONE !== 1'b0)
        errs++;
      tick();
    end
    chk("init_sweep_errors", 64'(errs), 64'h0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    prefill = 1'b1;
    bus.SRAM_Q = 64'h0;
    idle();

    //                req0 req1 wen0   wen1   a0       a1       d0     d1     rdy0 rdy1 rv0  rv1  cen  exp_a    rdata
    tbl[0]  = '{1'b0,1'b0,8'hFF,8'hFF,12'h000,12'h000,64'h0,64'h0,1'b0,1'b0,1'b0,1'b1,1'b1,12'h000,64'h0};
    tbl[1]  = '{1'b1,1'b0,8'h00,8'hFF,12'h010,12'h000,DB,   64'h0,1'b1,1'b0,1'b0,1'b0,1'b0,12'h010,64'h0};
    tbl[2]  = '{1'b1,1'b0,8'hFF,8'hFF,12'h010,12'h000,64'h0,64'h0,1'b1,1'b0,1'b0,1'b0,1'b0,12'h010,64'h0};
    tbl[3]  = '{1'b0,1'b0,8'hFF,8'hFF,12'h000,12'h000,64'h0,64'h0,1'b0,1'b0,1'b1,1'b0,1'b1,12'h000,DB};
    tbl[4]  = '{1'b0,1'b1,8'hFF,8'hFE,12'h000,12'h020,64'h0,BW,   1'b0,1'b1,1'b0,1'b0,1'b0,12'h020,64'h0};
    tbl[5]  = '{1'b0,1'b1,8'hFF,8'hFF,12'h000,12'h020,64'h0,64'h0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h020,64'h0};
    tbl[6]  = '{1'b1,1'b1,8'hFF,8'hFF,12'h010,12'h020,64'h0,64'h0,1'b1,1'b0,1'b0,1'b1,1'b0,12'h010,AA};
    tbl[7]  = '{1'b1,1'b1,8'hFF,8'hFF,12'h010,12'h020,64'h0,64'h0,1'b0,1'b1,1'b1,1'b0,1'b0,12'h020,DB};
    tbl[8]  = '{1'b1,1'b1,8'hFF,8'hFF,12'h010,12'h020,64'h0,64'h0,1'b1,1'b0,1'b0,1'b1,1'b0,12'h010,AA};
    tbl[9]  = '{1'b1,1'b1,8'hFF,8'hFF,12'h010,12'h020,64'h0,64'h0,1'b0,1'b1,1'b1,1'b0,1'b0,12'h020,DB};
    tbl[10] = '{1'b0,1'b0,8'hFF,8'hFF,12'h000,12'h000,64'h0,64'h0,1'b0,1'b0,1'b0,1'b1,1'b1,12'h000,AA};
    tbl[11] = '{1'b0,1'b1,8'hFF,8'hFF,12'h000,12'h020,64'h0,64'h0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h020,64'h0};
    tbl[12] = '{1'b1,1'b1,8'hFF,8'hFF,12'h010,12'h020,64'h0,64'h0,1'b1,1'b0,1'b0,1'b1,1'b0,12'h010,AA};
    tbl[13] = '{1'b0,1'b0,8'hFF,8'hFF,12'h000,12'h000,64'h0,64'h0,1'b0,1'b0,1'b1,1'b0,1'b1,12'h000,DB};

    // Reset values while RESET is held.
    tick();
    prefill = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_cen",       64'(bus.SRAM_CEn),  64'h1);
    chk("rst_wen",       64'(bus.SRAM_WEn),  64'hFF);
    chk("rst_ready",     64'({bus.P1_READY, bus.P0_READY}),   64'h0);
    chk("rst_rvalid",    64'({bus.P1_RVALID, bus.P0_RVALID}), 64'h0);
    chk("rst_init_done", 64'(bus.INIT_DONE), 64'h0);
    tick();

    // Zero-fill with P1 requesting a read of 0x005 the whole time.
    rst = 1'b0;
    bus.P1_REQ = 1'b1; bus.P1_WEn = 8'hFF; bus.P1_A = 12'h005;
    wait_init();
    @(negedge clk);
    chk("run_init_done", 64'(bus.INIT_DONE), 64'h1);
    chk("run_p1_ready",  64'(bus.P1_READY),  64'h1);
    chk("run_p0_ready",  64'(bus.P0_READY),  64'h0);
    chk("run_cen",       64'(bus.SRAM_CEn),  64'h0);
    chk("run_a",         64'(bus.SRAM_A),    64'h005);
    chk("run_wen",       64'(bus.SRAM_WEn),  64'hFF);
    tick();

    // Table: write/read, byte write, alternating ties, single-requester grant.
    for (int r = 0; r < 14; r++) begin
      bus.P0_REQ = tbl[r].req0; bus.P0_WEn = tbl[r].wen0; bus.P0_A = tbl[r].a0; bus.P0_D = tbl[r].d0;
      bus.P1_REQ = tbl[r].req1; bus.P1_WEn = tbl[r].wen1; bus.P1_A = tbl[r].a1; bus.P1_D = tbl[r].d1;
      @(negedge clk);
      chk($sformatf("row%0d_p0_ready", r),  64'(bus.P0_READY),  64'(tbl[r].rdy0));
      chk($sformatf("row%0d_p1_ready", r),  64'(bus.P1_READY),  64'(tbl[r].rdy1));
      chk($sformatf("row%0d_p0_rvalid", r), 64'(bus.P0_RVALID), 64'(tbl[r].rv0));
      chk($sformatf("row%0d_p1_rvalid", r), 64'(bus.P1_RVALID), 64'(tbl[r].rv1));
      chk($sformatf("row%0d_cen", r),       64'(bus.SRAM_CEn),  64'(tbl[r].cen));
      if (!tbl[r].cen) chk($sformatf("row%0d_addr", r), 64'(bus.SRAM_A), 64'(tbl[r].exp_a));
      if (tbl[r].rv0)  chk($sformatf("row%0d_p0_rdata", r), bus.P0_RDATA, tbl[r].rdata);
      if (tbl[r].rv1)  chk($sformatf("row%0d_p1_rdata", r), bus.P1_RDATA, tbl[r].rdata);
      tick();
    end

    // Reset the cycle after a P1 read grant: response squashed, fill restarts.
    bus.P1_REQ = 1'b1; bus.P1_WEn = 8'hFF; bus.P1_A = 12'h020;
    @(negedge clk);
    chk("t5_p1_ready", 64'(bus.P1_READY), 64'h1);
    tick();
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("t5_rvalid_squash", 64'(bus.P1_RVALID), 64'h0);
    chk("t5_done_drop",     64'(bus.INIT_DONE), 64'h0);
    chk("t5_cen_idle",      64'(bus.SRAM_CEn),  64'h1);
    tick();
    rst = 1'b0;
    wait_init();

    // Earlier write to 0x010 must have been overwritten by the refill.
    bus.P0_REQ = 1'b1; bus.P0_WEn = 8'hFF; bus.P0_A = 12'h010;
    @(negedge clk);
    chk("t5_done_again", 64'(bus.INIT_DONE), 64'h1);
    chk("t5_p0_ready",   64'(bus.P0_READY),  64'h1);
    tick();
    idle();
    @(negedge clk);
    chk("t5_p0_rvalid", 64'(bus.P0_RVALID), 64'h1);
    chk("t5_rezero",    bus.P0_RDATA,       64'h0);
    tick();

    // Last winner was P0; after reset the first tie must still go to P0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init();
    bus.P0_REQ = 1'b1; bus.P0_WEn = 8'hFF; bus.P0_A = 12'h001;
    bus.P1_REQ = 1'b1; bus.P1_WEn = 8'hFF; bus.P1_A = 12'h002;
    @(negedge clk);
    chk("rr_reset_p0_ready", 64'(bus.P0_READY), 64'h1);
    chk("rr_reset_p1_ready", 64'(bus.P1_READY), 64'h0);
    tick();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
